// File: rtl/seg7_pkg.sv
// Shared segment constants for the multiplexed 7-segment driver.
// Segment order is {g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

    localparam int unsigned NIB_W = 4;
    localparam int unsigned SEG_W = 7;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

    localparam logic [SEG_W-1:0] SEG_0 = 7'h40;
    localparam logic [SEG_W-1:0] SEG_1 = 7'h79;
    localparam logic [SEG_W-1:0] SEG_2 = 7'h24;
    localparam logic [SEG_W-1:0] SEG_3 = 7'h30;
    localparam logic [SEG_W-1:0] SEG_4 = 7'h19;
    localparam logic [SEG_W-1:0] SEG_5 = 7'h12;
    localparam logic [SEG_W-1:0] SEG_6 = 7'h02;
    localparam logic [SEG_W-1:0] SEG_7 = 7'h78;
    localparam logic [SEG_W-1:0] SEG_8 = 7'h00;
    localparam logic [SEG_W-1:0] SEG_9 = 7'h18;
    localparam logic [SEG_W-1:0] SEG_A = 7'h08;
    localparam logic [SEG_W-1:0] SEG_B = 7'h03;
    localparam logic [SEG_W-1:0] SEG_C = 7'h46;
    localparam logic [SEG_W-1:0] SEG_D = 7'h21;
    localparam logic [SEG_W-1:0] SEG_E = 7'h06;
    localparam logic [SEG_W-1:0] SEG_F = 7'h0E;

endpackage

// File: rtl/seg7_decode.sv
// Combinational nibble-to-segment decode.
// Define SEG7_HEX_EN to show A..F for nibbles 10..15; otherwise they blank.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [NIB_W-1:0] nib,
    output logic [SEG_W-1:0] seg_c
);

    always_comb begin
        seg_c = SEG_BLANK;
        case (nib)
            4'd0:  seg_c = SEG_0;
            4'd1:  seg_c = SEG_1;
            4'd2:  seg_c = SEG_2;
            4'd3:  seg_c = SEG_3;
            4'd4:  seg_c = SEG_4;
            4'd5:  seg_c = SEG_5;
            4'd6:  seg_c = SEG_6;
            4'd7:  seg_c = SEG_7;
            4'd8:  seg_c = SEG_8;
            4'd9:  seg_c = SEG_9;
`ifdef SEG7_HEX_EN
            4'd10: seg_c = SEG_A;
            4'd11: seg_c = SEG_B;
            4'd12: seg_c = SEG_C;
            4'd13: seg_c = SEG_D;
            4'd14: seg_c = SEG_E;
            4'd15: seg_c = SEG_F;
`else
            4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15: seg_c = SEG_BLANK;
`endif
            default: seg_c = SEG_BLANK;
        endcase
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed DIGITS-digit 7-segment driver with frame-synchronous update,
// ghost guard, leading-zero blanking and decimal points. Hex digits need SEG7_HEX_EN.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int unsigned DIGITS = 4,
    parameter int unsigned DIV    = 1000
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_ena,
    input  logic                    i_load,
    input  logic [NIB_W*DIGITS-1:0] i_value,
    input  logic [DIGITS-1:0]       i_dp,
    input  logic                    i_lzb,
    output logic [SEG_W-1:0]        o_seg,
    output logic                    o_dp,
    output logic [DIGITS-1:0]       o_an,
    output logic                    o_frame
);

    localparam int unsigned VAL_W  = NIB_W * DIGITS;
    localparam int unsigned PCNT_W = $clog2(DIV);
    localparam int unsigned IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic [PCNT_W-1:0] pcnt;
    logic [IDX_W-1:0]  idx;
    logic [VAL_W-1:0]  shadow_value;
    logic [DIGITS-1:0] shadow_dp;
    logic [VAL_W-1:0]  active_value;
    logic [DIGITS-1:0] active_dp;
    logic              pending;

    logic              tick_c;
    logic              wrap_c;
    logic [VAL_W-1:0]  upper_c;
    logic [NIB_W-1:0]  cur_nib_c;
    logic              lz_blank_c;
    logic              cur_dp_c;
    logic [SEG_W-1:0]  dec_seg_c;
    logic [DIGITS-1:0] an_lit_c;

    assign tick_c = (pcnt == PCNT_W'(DIV - 1));
    assign wrap_c = tick_c && (idx == IDX_W'(DIGITS - 1));

    // Prescaler and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            idx  <= '0;
        end else if (tick_c) begin
            pcnt <= '0;
            idx  <= wrap_c ? '0 : idx + IDX_W'(1);
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

    // Shadow captures loads; active only changes on a frame wrap so a frame never tears
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_value <= '0;
            shadow_dp    <= '0;
            active_value <= '0;
            active_dp    <= '0;
            pending      <= 1'b0;
        end else begin
            if (wrap_c && pending) begin
                active_value <= shadow_value;
                active_dp    <= shadow_dp;
            end
            if (i_load) begin
                shadow_value <= i_value;
                shadow_dp    <= i_dp;
                pending      <= 1'b1;
            end else if (wrap_c) begin
                pending      <= 1'b0;
            end
        end
    end

    // Current digit is blank under LZB when it and every digit above it are zero
    assign upper_c    = active_value >> (NIB_W * 32'(idx));
    assign cur_nib_c  = NIB_W'(upper_c);
    assign lz_blank_c = i_lzb && (idx != '0) && (upper_c == '0);
    assign cur_dp_c   = active_dp[idx];
    assign an_lit_c   = ~(DIGITS'(1) << idx);

    seg7_decode u_decode (
        .nib   (cur_nib_c),
        .seg_c (dec_seg_c)
    );

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            o_seg   <= SEG_BLANK;
            o_dp    <= 1'b1;
            o_an    <= '1;
            o_frame <= 1'b0;
        end else begin
            o_frame <= wrap_c;
            if (!i_ena) begin
                o_seg <= SEG_BLANK;
                o_dp  <= 1'b1;
                o_an  <= '1;
            end else begin
                o_seg <= lz_blank_c ? SEG_BLANK : dec_seg_c;
                o_dp  <= ~cur_dp_c;
                o_an  <= (pcnt == '0) ? '1 : an_lit_c;
            end
        end
    end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, DIV=4): directed steps plus random traffic
// against a cycle-count based reference model. Honours SEG7_HEX_EN like the design.
module tb_seg7_scan_driver;

    localparam int unsigned DIGITS = 4;
    localparam int unsigned DIV    = 4;

    logic        clk;
    logic        rst_n;
    logic        i_ena;
    logic        i_load;
    logic [15:0] i_value;
    logic [3:0]  i_dp;
    logic        i_lzb;
    logic [6:0]  o_seg;
    logic        o_dp;
    logic [3:0]  o_an;
    logic        o_frame;

    int checks;
    int failures;

    // Reference model: time since reset release plus shadow/active display state
    int          t;
    logic [15:0] m_shadow, m_active;
    logic [3:0]  m_sdp, m_adp;
    bit          m_pend;

    seg7_scan_driver #(.DIGITS(DIGITS), .DIV(DIV)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_ena   (i_ena),
        .i_load  (i_load),
        .i_value (i_value),
        .i_dp    (i_dp),
        .i_lzb   (i_lzb),
        .o_seg   (o_seg),
        .o_dp    (o_dp),
        .o_an    (o_an),
        .o_frame (o_frame)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] codes [16];
        codes = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h18,
`ifdef SEG7_HEX_EN
                  7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
`else
                  7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F};
`endif
        return codes[n];
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0d", tag, obs, exp, t);
        end
    endtask

    task automatic model_reset();
        t = 0;
        m_shadow = '0; m_active = '0; m_sdp = '0; m_adp = '0; m_pend = 0;
    endtask

    function automatic bit next_is_wrap();
        return ((t % DIV) == DIV - 1) && (((t / DIV) % DIGITS) == DIGITS - 1);
    endfunction

    // One clock: predict from pre-edge state, compare after the edge, advance model
    task automatic step();
        int          p, d;
        logic [15:0] upper;
        logic [3:0]  e_an;
        logic [6:0]  e_seg;
        logic        e_dp, e_frame, ld;
        logic [15:0] v;
        logic [3:0]  dpv;
        p       = t % DIV;
        d       = (t / DIV) % DIGITS;
        upper   = m_active >> (4 * d);
        e_frame = next_is_wrap();
        if (!i_ena) begin
            e_an = 4'hF; e_seg = 7'h7F; e_dp = 1'b1;
        end else begin
            e_an  = (p == 0) ? 4'hF : ~(4'b0001 << d);
            e_seg = (i_lzb && d != 0 && upper == 16'h0) ? 7'h7F : seg_of(upper[3:0]);
            e_dp  = ~m_adp[d];
        end
        ld = i_load; v = i_value; dpv = i_dp;
        @(posedge clk);
        #1;
        check("an", 32'(o_an), 32'(e_an));
        check("frame", 32'(o_frame), 32'(e_frame));
        if (e_an != 4'hF || !i_ena) begin
            check("seg", 32'(o_seg), 32'(e_seg));
            check("dp", 32'(o_dp), 32'(e_dp));
        end
        if (e_frame && m_pend) begin
            m_active = m_shadow; m_adp = m_sdp; m_pend = 0;
        end
        if (ld) begin
            m_shadow = v; m_sdp = dpv; m_pend = 1;
        end
        t++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic load(input logic [15:0] v, input logic [3:0] dp);
        i_value = v; i_dp = dp; i_load = 1'b1;
        step();
        i_load = 1'b0;
    endtask

    // Advance until the next edge is a frame wrap (bounded by one frame)
    task automatic to_wrap();
        for (int i = 0; i < DIGITS * DIV && !next_is_wrap(); i++) step();
    endtask

    task automatic check_blank(input string tag);
        check({tag, "_an"}, 32'(o_an), 32'hF);
        check({tag, "_seg"}, 32'(o_seg), 32'h7F);
        check({tag, "_dp"}, 32'(o_dp), 32'h1);
        check({tag, "_frame"}, 32'(o_frame), 32'h0);
    endtask

    initial begin
        checks = 0; failures = 0;
        clk = 1'b0; rst_n = 1'b0;
        i_ena = 1'b1; i_load = 1'b0; i_value = '0; i_dp = '0; i_lzb = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_blank("reset");
        rst_n = 1'b1;

        // First lit anode appears on the second cycle after release
        step();
        step();
        check("first_an", 32'(o_an), 32'hE);

        // Basic scan of 1234
        load(16'h1234, 4'h0);
        run(3 * DIGITS * DIV);

        // Async reset mid-scan while a digit is lit
        #2 rst_n = 1'b0;
        #1 check_blank("midrst");
        @(posedge clk); #1 rst_n = 1'b1;
        model_reset();
        load(16'h1234, 4'h0);
        run(2 * DIGITS * DIV);

        // Last load before the wrap wins
        run(5);
        load(16'h5678, 4'h0);
        run(2);
        load(16'h9999, 4'h0);
        to_wrap();
        step();
        step();
        step();
        check("sync_9999", 32'(o_seg), 32'h18);
        run(DIGITS * DIV);

        // Load coincident with the wrap is deferred one frame
        to_wrap();
        load(16'h4321, 4'h0);
        run(2 * DIGITS * DIV);

        // Leading-zero blanking
        i_lzb = 1'b1;
        load(16'h0070, 4'h0);
        run(2 * DIGITS * DIV);
        load(16'h0000, 4'h0);
        run(2 * DIGITS * DIV);

        // Enable gating and re-enable mid-frame
        i_lzb = 1'b0;
        load(16'h2468, 4'b0100);
        run(DIGITS * DIV);
        i_ena = 1'b0;
        run(DIGITS * DIV + 6);
        i_ena = 1'b1;
        run(2 * DIGITS * DIV);

        // Hex digits
        load(16'hABCF, 4'h0);
        run(2 * DIGITS * DIV);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            i_load  = ($urandom_range(0, 7) == 0);
            i_value = 16'($urandom);
            i_dp    = 4'($urandom);
            if ($urandom_range(0, 15) == 0) i_lzb = ~i_lzb;
            i_ena   = ($urandom_range(0, 9) != 0);
            step();
        end
        i_load = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
# seg7_scan_driver

Parametrised, time-multiplexed multi-digit 7-segment driver. It is the successor to the single-digit BCD decoder. It latches a packed value of DIGITS nibbles through a load strobe and scans one digit at a time on shared active-low segment lines with per-digit active-low anode enables. It adds frame-synchronous update, a ghost-guard blank, leading-zero blanking and per-digit decimal points, and sits between the counter/datapath logic and the board's display pins.

## Interface
- DIGITS, 4: number of multiplexed digits, 1..8.
- DIV, 1000: clk cycles per digit slot, ≥2.
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- i_ena  in  1  display enable; low blanks all outputs while scanning keeps running.
- i_load  in  1  one-cycle strobe; captures i_value/i_dp into the shadow register.
- i_value  in  4*DIGITS  packed digits, nibble 0 (bits 3:0) = rightmost digit.
- i_dp  in  DIGITS  decimal point per digit, 1 = lit.
- i_lzb  in  1  leading-zero blanking enable.
- o_seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- o_dp  out  1  decimal point, active-low.
- o_an  out  DIGITS  anode enables, active-low, one-hot-low when lit.
- o_frame  out  1  one-cycle pulse at each frame wrap.

## Operation
- Prescaler pcnt counts 0..DIV-1 and wraps. A tick occurs when pcnt==DIV-1.
- Digit index idx advances on each tick and wraps from DIGITS-1 to 0. The tick that wraps idx is the frame wrap.
- Shadow register: i_load writes i_value/i_dp and sets pending. A load while pending is set overwrites the shadow; the last load wins.
- Active register: on frame wrap with pending set, active <= shadow and pending clears.
  - A load in the same cycle as the wrap goes to the shadow, keeps pending set, and is transferred on the next wrap.
- Decode of active nibble: 0..9 use the codes 40,79,24,30,19,12,02,78,00,18 (hex). 10..15 decode per Configuration.
- Leading-zero blanking: with i_lzb=1, zero digits above the most significant nonzero digit are blanked (seg 7F, dp still honoured). Digit 0 is never blanked, so a value of 0 shows "0".
- Ghost guard: in the cycle where pcnt==0, all anodes are off (o_an all ones). In the remaining DIV-1 cycles of the slot, o_an[idx]=0.
- i_ena=0: o_an all ones, o_seg=7F, o_dp=1. pcnt, idx, load and transfer logic all continue.

## Timing
- All outputs are registered and reflect pcnt/idx of the previous cycle, giving one cycle of latency.
- Reset values: o_seg=7F, o_dp=1, o_an=all ones, o_frame=0, pcnt=0, idx=0, shadow=0, active=0, pending=0.
- Reset asserted mid-frame clears everything immediately (asynchronous). Scanning restarts at digit 0 with pcnt=0 after rst_n deasserts.
- o_frame is high for exactly one cycle, the cycle after the wrap tick.
- A new value is visible from the start of the first full frame after the wrap that transfers it. Worst-case load-to-display latency is DIGITS*DIV+2 cycles.
- Frame period is DIGITS*DIV cycles. Each digit is lit for DIV-1 cycles.

## Configuration
- SEG7_HEX_EN defined: nibbles 10..15 decode to A=08, b=03, C=46, d=21, E=06, F=0E.
- SEG7_HEX_EN undefined: nibbles 10..15 decode to 7F (blank).
- Leading-zero detection treats only nibble value 0 as zero in both builds.

## Structure
- Package seg7_pkg holds the segment constants (SEG_BLANK=7'h7F, digit codes 0..F) and a localparam for the nibble width.
- One sub-module, seg7_decode, provides the combinational nibble-to-segment decode, including the SEG7_HEX_EN branch. It is instantiated once on the muxed nibble.
- The top level contains the prescaler, idx counter, shadow/active registers, the leading-zero mask and the output registers.

## Test plan
- Reset: hold rst_n=0 mid-scan → o_an=F, o_seg=7F, o_dp=1 asynchronously. After release, the first lit anode is o_an=E, appearing on cycle 2.
- Scan (DIGITS=4, DIV=4, load 16'h1234, i_lzb=0) → after the next wrap, the per-slot sequence is 4:19, 3:30, 2:24, 1:79. Each digit is lit for 3 cycles with a 1-cycle all-off guard. o_frame pulses every 16 cycles.
- Frame sync: load 16'h5678 mid-frame, then 16'h9999 before the wrap → only 9999 is displayed, starting at the frame after the wrap. A load coincident with the wrap tick is deferred one frame.
- Leading-zero blanking: load 16'h0070 with i_lzb=1 → digits 3 and 2 show 7F, digit 1 shows 78, digit 0 shows 40. Load 16'h0000 → only digit 0 shows 40.
- Enable and dp: i_ena=0 → outputs blank and o_frame keeps pulsing. Re-enable mid-frame → display resumes at the current idx. i_dp=4'b0100 → o_dp=0 only in the digit-2 slot.
- Hex: load 16'hABCF → with SEG7_HEX_EN, shows 08,03,46,0E; without it, all four digits show 7F.
